// File: rtl/oc8051_xram_pkg.sv
//============================================================================
// Module   : oc8051_xram_pkg
// Purpose  : Shared types and constants for the XRAM arbiter: FSM state
//            encoding, page-table / illegal-access register window bounds,
//            accesser-id width and address-region decode helpers.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package oc8051_xram_pkg;

    // Width of the accesser id reported to the page table
    localparam int SRC_W = 3;

    // Register windows routed to the page table instead of XRAM
    localparam logic [15:0] PT_WR_START = 16'hFF80;
    localparam logic [15:0] PT_RD_END   = 16'hFFBF;
    localparam logic [15:0] IA_START    = 16'hFFC0;
    localparam logic [15:0] IA_END      = 16'hFFC3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MEM   = 3'd2,
        REG   = 3'd3,
        RESP  = 3'd4,
        ERR   = 3'd5
    } state_t;

    function automatic logic is_pt(input logic [15:0] a);
        return (a >= PT_WR_START) && (a <= PT_RD_END);
    endfunction

    function automatic logic is_ia(input logic [15:0] a);
        return (a >= IA_START) && (a <= IA_END);
    endfunction

    function automatic logic is_reg(input logic [15:0] a);
        return is_pt(a) || is_ia(a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/oc8051_rr_arbiter.sv
//============================================================================
// Module   : oc8051_rr_arbiter
// Purpose  : Combinational round-robin request picker. The search starts at
//            i_ptr and wraps modulo NUM_MST; the first asserted request wins.
// Ports    : i_req   - request vector, one bit per master
//            i_ptr   - index where the search starts
//            o_grant - winning master index
//            o_valid - at least one request present
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module oc8051_rr_arbiter
    import oc8051_xram_pkg::*;
#(
    parameter int NUM_MST = 4
) (
    input  logic [NUM_MST-1:0] i_req,
    input  logic [SRC_W-1:0]   i_ptr,
    output logic [SRC_W-1:0]   o_grant,
    output logic               o_valid
);

    // Doubling the request vector turns the wrap-around search into a
    // plain shift: bit k of the shifted vector is master (ptr + k) mod N.
    logic [2*NUM_MST-1:0] w_dbl;
    int                   w_sum;

    assign w_dbl = {i_req, i_req} >> i_ptr;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_sum   = 0;
        // Walk from the far end so the nearest request to i_ptr is the
        // last assignment and therefore wins.
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_sum = int'(i_ptr) + k;
                if (w_sum >= NUM_MST) begin
                    w_sum = w_sum - NUM_MST;
                end
                o_grant = SRC_W'(w_sum);
                o_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/oc8051_xram_arbiter.sv
//============================================================================
// Module   : oc8051_xram_arbiter
// Purpose  : Arbitrates XRAM requests from NUM_MST masters onto one XRAM
//            port. Memory accesses are first permission-checked by the page
//            table (one CHECK cycle); denied ones complete with m_err.
//            Accesses to 0xFF80-0xFFC3 go to the page-table / illegal-access
//            register strobes without a permission check.
// Ports    : m_*       - per-master request side (stb/wr/addr/wdata in,
//                        ack/err pulses and shared rdata out)
//            chk_*     - page-table access-check interface
//            pt_*/ia_* - page-table and illegal-access register strobes
//            mem_*     - XRAM port
// Options  : OC8051_XRAM_ARB_TIMEOUT_EN - when defined, MEM and REG give up
//            after TIMEOUT cycles without an ack and complete with m_err.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module oc8051_xram_arbiter
    import oc8051_xram_pkg::*;
#(
    parameter int NUM_MST = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MST-1:0]     m_stb,
    input  logic [NUM_MST-1:0]     m_wr,
    input  logic [16*NUM_MST-1:0]  m_addr,
    input  logic [8*NUM_MST-1:0]   m_wdata,
    output logic [NUM_MST-1:0]     m_ack,
    output logic [NUM_MST-1:0]     m_err,
    output logic [7:0]             m_rdata,
    output logic [15:0]            chk_addr,
    output logic                   chk_wr,
    output logic                   chk_stb,
    output logic [SRC_W-1:0]       chk_src,
    input  logic                   chk_wr_en,
    input  logic                   chk_rd_en,
    output logic                   pt_stb,
    output logic                   ia_stb,
    input  logic                   pt_ack,
    input  logic                   ia_ack,
    input  logic [7:0]             pt_rdata,
    input  logic [7:0]             ia_rdata,
    output logic                   mem_stb,
    output logic                   mem_wr,
    output logic [15:0]            mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata,
    input  logic                   mem_ack
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [SRC_W-1:0]   r_cur_src;
    logic               r_cur_wr;
    logic [15:0]        r_cur_addr;
    logic [7:0]         r_cur_wdata;
    logic [15:0]        r_chk_addr;
    logic               r_chk_wr;
    logic [SRC_W-1:0]   r_chk_src;
    logic [7:0]         r_rdata;

    logic [SRC_W-1:0]   w_gnt;
    logic               w_gnt_valid;
    logic               w_gnt_wr;
    logic [15:0]        w_gnt_addr;
    logic [7:0]         w_gnt_wdata;
    logic               w_gnt_reg;
    logic               w_perm;
    logic               w_cur_ia;
    logic               w_reg_ack;
    logic [7:0]         w_reg_rdata;
    logic               w_tmo;

    oc8051_rr_arbiter #(
        .NUM_MST (NUM_MST)
    ) u_rr (
        .i_req   (m_stb),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_gnt),
        .o_valid (w_gnt_valid)
    );

    // Select the granted master's request fields
    always_comb begin
        w_gnt_wr    = 1'b0;
        w_gnt_addr  = '0;
        w_gnt_wdata = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (w_gnt == SRC_W'(i)) begin
                w_gnt_wr    = m_wr[i];
                w_gnt_addr  = m_addr[16*i +: 16];
                w_gnt_wdata = m_wdata[8*i +: 8];
            end
        end
    end

    assign w_gnt_reg   = is_reg(w_gnt_addr);
    assign w_cur_ia    = is_ia(r_cur_addr);
    assign w_reg_ack   = w_cur_ia ? ia_ack : pt_ack;
    assign w_reg_rdata = w_cur_ia ? ia_rdata : pt_rdata;

`ifdef OC8051_XRAM_ARB_TIMEOUT_EN
    logic [7:0] r_tmo;

    // Counter sits at zero outside MEM/REG, so it is clear on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else if ((r_state == MEM) || (r_state == REG)) begin
            r_tmo <= r_tmo + 8'd1;
        end else begin
            r_tmo <= '0;
        end
    end

    // Fires in the TIMEOUT-th waiting cycle, so MEM/REG last TIMEOUT cycles
    assign w_tmo = (r_tmo == 8'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_tmo            = 1'b0;
`endif

    // Next-state and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_perm      = 1'b0;
        chk_stb     = 1'b0;
        pt_stb      = 1'b0;
        ia_stb      = 1'b0;
        mem_stb     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nxt = w_gnt_reg ? REG : CHECK;
                end
            end
            CHECK: begin
                chk_stb     = 1'b1;
                w_perm      = r_cur_wr ? chk_wr_en : chk_rd_en;
                w_state_nxt = w_perm ? MEM : ERR;
            end
            MEM: begin
                mem_stb = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = RESP;
                end else if (w_tmo) begin
                    w_state_nxt = ERR;
                end
            end
            REG: begin
                pt_stb = !w_cur_ia;
                ia_stb = w_cur_ia;
                if (w_reg_ack) begin
                    w_state_nxt = RESP;
                end else if (w_tmo) begin
                    w_state_nxt = ERR;
                end
            end
            RESP:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_cur_src   <= '0;
            r_cur_wr    <= 1'b0;
            r_cur_addr  <= '0;
            r_cur_wdata <= '0;
            r_chk_addr  <= '0;
            r_chk_wr    <= 1'b0;
            r_chk_src   <= '0;
            r_rdata     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_gnt_valid) begin
                r_cur_src   <= w_gnt;
                r_cur_wr    <= w_gnt_wr;
                r_cur_addr  <= w_gnt_addr;
                r_cur_wdata <= w_gnt_wdata;
                r_rr_ptr    <= (w_gnt == SRC_W'(NUM_MST - 1)) ? '0 : w_gnt + 3'd1;
                // Loading the check outputs at grant makes them valid during
                // CHECK and keeps them stable through REG accesses.
                if (!w_gnt_reg) begin
                    r_chk_addr <= w_gnt_addr;
                    r_chk_wr   <= w_gnt_wr;
                    r_chk_src  <= w_gnt;
                end
            end
            if ((r_state == MEM) && mem_ack) begin
                r_rdata <= mem_rdata;
            end else if ((r_state == REG) && w_reg_ack) begin
                r_rdata <= w_reg_rdata;
            end else if (w_state_nxt == ERR) begin
                r_rdata <= '0;
            end
        end
    end

    // Completion pulses go to the master that owns the transaction
    always_comb begin
        m_ack = '0;
        m_err = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            m_ack[i] = (r_state == RESP) && (r_cur_src == SRC_W'(i));
            m_err[i] = (r_state == ERR)  && (r_cur_src == SRC_W'(i));
        end
    end

    assign m_rdata   = r_rdata;
    assign chk_addr  = r_chk_addr;
    assign chk_wr    = r_chk_wr;
    assign chk_src   = r_chk_src;
    assign mem_wr    = r_cur_wr;
    assign mem_addr  = r_cur_addr;
    assign mem_wdata = r_cur_wdata;

endmodule

`default_nettype wire

// File: tb/tb_oc8051_xram_arbiter.sv
//============================================================================
// Module   : tb_oc8051_xram_arbiter
// Purpose  : Scoreboard testbench for oc8051_xram_arbiter. Stimulus pushes
//            expected completions (master, ack/err, rdata, cycle) into a
//            queue; a negedge monitor pops and compares on every m_ack/m_err.
// Options  : OC8051_XRAM_ARB_TIMEOUT_EN - adds the timeout scenario.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_oc8051_xram_arbiter;

    localparam int NM = 4;

    logic            clk;
    logic            rst;
    logic [NM-1:0]   m_stb;
    logic [NM-1:0]   m_wr;
    logic [16*NM-1:0] m_addr;
    logic [8*NM-1:0] m_wdata;
    logic [NM-1:0]   m_ack;
    logic [NM-1:0]   m_err;
    logic [7:0]      m_rdata;
    logic [15:0]     chk_addr;
    logic            chk_wr;
    logic            chk_stb;
    logic [2:0]      chk_src;
    logic            chk_wr_en;
    logic            chk_rd_en;
    logic            pt_stb;
    logic            ia_stb;
    logic            pt_ack;
    logic            ia_ack;
    logic [7:0]      pt_rdata;
    logic [7:0]      ia_rdata;
    logic            mem_stb;
    logic            mem_wr;
    logic [15:0]     mem_addr;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;
    logic            mem_ack;
    logic            mem_hold;
    logic            stray;

    oc8051_xram_arbiter #(
        .NUM_MST (NM),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_stb     (m_stb),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .chk_addr  (chk_addr),
        .chk_wr    (chk_wr),
        .chk_stb   (chk_stb),
        .chk_src   (chk_src),
        .chk_wr_en (chk_wr_en),
        .chk_rd_en (chk_rd_en),
        .pt_stb    (pt_stb),
        .ia_stb    (ia_stb),
        .pt_ack    (pt_ack),
        .ia_ack    (ia_ack),
        .pt_rdata  (pt_rdata),
        .ia_rdata  (ia_rdata),
        .mem_stb   (mem_stb),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Zero-wait responders; memory data is a fixed function of the address
    assign mem_ack   = (mem_stb & ~mem_hold) | stray;
    assign pt_ack    = pt_stb;
    assign ia_ack    = ia_stb;
    assign mem_rdata = (mem_addr == 16'h1234) ? 8'hA5 : (mem_addr[15:8] ^ mem_addr[7:0]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         src;
        bit         err;
        logic [7:0] rd;
        int         at;
    } exp_t;
    exp_t q[$];

    // Side-channel observations for the stimulus to inspect
    int          n_chk = 0, n_mem = 0, n_pt = 0, n_ia = 0;
    int          s_chk, s_mem, s_pt, s_ia;
    logic [15:0] l_chk_addr;
    logic        l_chk_wr;
    logic [2:0]  l_chk_src;
    logic        l_mem_wr;
    logic [15:0] l_mem_addr;
    logic [7:0]  l_mem_wdata;

    always @(negedge clk) begin
        if (!rst) begin
            if (chk_stb) begin
                n_chk++;
                l_chk_addr = chk_addr;
                l_chk_wr   = chk_wr;
                l_chk_src  = chk_src;
            end
            if (mem_stb) begin
                n_mem++;
                l_mem_wr    = mem_wr;
                l_mem_addr  = mem_addr;
                l_mem_wdata = mem_wdata;
            end
            if (pt_stb) n_pt++;
            if (ia_stb) n_ia++;
            if ((|m_ack) || (|m_err)) begin
                if (q.size() == 0) begin
                    check("spurious_cpl", {24'd0, m_err, m_ack}, 32'd0);
                end else begin
                    exp_t e;
                    logic [NM-1:0] one_hot;
                    e = q.pop_front();
                    one_hot = NM'(1) << e.src;
                    check("cpl_ack", {28'd0, m_ack}, e.err ? 32'd0 : {28'd0, one_hot});
                    check("cpl_err", {28'd0, m_err}, e.err ? {28'd0, one_hot} : 32'd0);
                    check("cpl_rdata", {24'd0, m_rdata}, {24'd0, e.rd});
                    check("cpl_cycle", cyc, e.at);
                end
            end
        end
    end

    task automatic snap();
        s_chk = n_chk;
        s_mem = n_mem;
        s_pt  = n_pt;
        s_ia  = n_ia;
    endtask

    // Hold each requesting master's stb until its ack/err has been seen
    task automatic wait_done(input int budget);
        int n;
        logic [NM-1:0] w;
        n = 0;
        while ((m_stb != '0) && (n < budget)) begin
            @(negedge clk);
            w = m_ack | m_err;
            @(posedge clk);
            #1;
            m_stb = m_stb & ~w;
            n++;
        end
        if (m_stb != '0) begin
            check("handshake_timeout", {28'd0, m_stb}, 32'd0);
            m_stb = '0;
        end
    endtask

    task automatic set_req(input int m, input bit wr, input logic [15:0] a, input logic [7:0] wd);
        m_wr[m]            = wr;
        m_addr[16*m +: 16] = a;
        m_wdata[8*m +: 8]  = wd;
        m_stb[m]           = 1'b1;
    endtask

    task automatic one(input int m, input bit wr, input logic [15:0] a, input logic [7:0] wd,
                       input bit wen, input bit ren, input bit e_err, input logic [7:0] e_rd,
                       input int lat);
        @(posedge clk);
        #1;
        chk_wr_en = wen;
        chk_rd_en = ren;
        snap();
        set_req(m, wr, a, wd);
        q.push_back('{m, e_err, e_rd, cyc + lat});
        wait_done(40);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int c;
        rst       = 1'b1;
        m_stb     = '0;
        m_wr      = '0;
        m_addr    = '0;
        m_wdata   = '0;
        chk_wr_en = 1'b0;
        chk_rd_en = 1'b0;
        pt_rdata  = 8'h11;
        ia_rdata  = 8'h9E;
        mem_hold  = 1'b0;
        stray     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_m_ack", {28'd0, m_ack}, 32'd0);
        check("rst_m_err", {28'd0, m_err}, 32'd0);
        check("rst_strobes", {28'd0, chk_stb, pt_stb, ia_stb, mem_stb}, 32'd0);
        check("rst_m_rdata", {24'd0, m_rdata}, 32'd0);
        check("rst_chk_addr", {16'd0, chk_addr}, 32'd0);

        // Round-robin: masters 0,2,3 together from rr_ptr=0 -> 0,2,3
        @(posedge clk);
        #1;
        chk_rd_en = 1'b1;
        set_req(0, 1'b0, 16'h1020, 8'h00);
        set_req(2, 1'b0, 16'h2040, 8'h00);
        set_req(3, 1'b0, 16'h3070, 8'h00);
        c = cyc;
        q.push_back('{0, 1'b0, 8'h30, c + 3});
        q.push_back('{2, 1'b0, 8'h60, c + 7});
        q.push_back('{3, 1'b0, 8'h40, c + 11});
        wait_done(60);

        // Pointer wrapped to 0 after master 3: master 0 beats master 3
        @(posedge clk);
        #1;
        set_req(3, 1'b0, 16'h3070, 8'h00);
        set_req(0, 1'b0, 16'h1020, 8'h00);
        c = cyc;
        q.push_back('{0, 1'b0, 8'h30, c + 3});
        q.push_back('{3, 1'b0, 8'h40, c + 7});
        wait_done(60);

        // Permitted read, zero-wait memory
        one(1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 3);
        check("rd_chk_pulses", n_chk - s_chk, 1);
        check("rd_chk_src", {29'd0, l_chk_src}, 32'd1);
        check("rd_chk_addr", {16'd0, l_chk_addr}, 32'h1234);
        check("rd_chk_wr", {31'd0, l_chk_wr}, 32'd0);
        check("rd_mem_cycles", n_mem - s_mem, 1);

        // Denied write: write permission low, read permission high
        one(0, 1'b1, 16'h0800, 8'h77, 1'b0, 1'b1, 1'b1, 8'h00, 2);
        check("den_chk_pulses", n_chk - s_chk, 1);
        check("den_chk_wr", {31'd0, l_chk_wr}, 32'd1);
        check("den_chk_src", {29'd0, l_chk_src}, 32'd0);
        check("den_mem_cycles", n_mem - s_mem, 0);

        // Page-table register write; check outputs must hold 0x0800
        one(2, 1'b1, 16'hFF85, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h11, 2);
        check("pt_pulses", n_pt - s_pt, 1);
        check("pt_mem_cycles", n_mem - s_mem, 0);
        check("pt_chk_pulses", n_chk - s_chk, 0);
        @(negedge clk);
        check("chk_addr_hold", {16'd0, chk_addr}, 32'h0800);

        // Illegal-access register read
        one(2, 1'b0, 16'hFFC1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h9E, 2);
        check("ia_pulses", n_ia - s_ia, 1);
        check("ia_pt_pulses", n_pt - s_pt, 0);

        // Permitted write reaches memory with master's data
        one(3, 1'b1, 16'h4000, 8'hC3, 1'b1, 1'b0, 1'b0, 8'h40, 3);
        check("wr_mem_wr", {31'd0, l_mem_wr}, 32'd1);
        check("wr_mem_addr", {16'd0, l_mem_addr}, 32'h4000);
        check("wr_mem_wdata", {24'd0, l_mem_wdata}, 32'hC3);
        check("wr_chk_src", {29'd0, l_chk_src}, 32'd3);

        // 0xFFC4 is memory space and gets checked (read denied)
        one(3, 1'b0, 16'hFFC4, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 2);
        check("ffc4_chk_pulses", n_chk - s_chk, 1);
        check("ffc4_chk_addr", {16'd0, l_chk_addr}, 32'hFFC4);
        check("ffc4_ia_pulses", n_ia - s_ia, 0);
        check("ffc4_mem_cycles", n_mem - s_mem, 0);

        // Edges of the register windows
        one(0, 1'b0, 16'hFF7F, 8'h00, 1'b0, 1'b1, 1'b0, 8'h80, 3);
        check("ff7f_pt_pulses", n_pt - s_pt, 0);
        one(1, 1'b0, 16'hFFBF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 2);
        check("ffbf_pt_pulses", n_pt - s_pt, 1);
        one(0, 1'b1, 16'hFFC3, 8'h55, 1'b0, 1'b0, 1'b0, 8'h9E, 2);
        check("ffc3_ia_pulses", n_ia - s_ia, 1);

        // Reset while waiting in MEM abandons the access silently
        @(posedge clk);
        #1;
        mem_hold  = 1'b1;
        chk_rd_en = 1'b1;
        set_req(1, 1'b0, 16'h0500, 8'h00);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_mem_stb", {31'd0, mem_stb}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_mem_stb", {31'd0, mem_stb}, 32'd0);
        check("rst_mid_cpl", {24'd0, m_err, m_ack}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_stb    = '0;
        mem_hold = 1'b0;
        repeat (4) @(posedge clk);
        one(1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 3);

`ifdef OC8051_XRAM_ARB_TIMEOUT_EN
        // Memory never acks: error after 4 cycles in MEM
        mem_hold = 1'b1;
        one(1, 1'b0, 16'h0600, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 6);
        check("tmo_mem_cycles", n_mem - s_mem, 4);
        mem_hold = 1'b0;
        // A late ack in IDLE must not produce a completion
        @(posedge clk);
        #1 stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        repeat (3) @(posedge clk);
        one(2, 1'b0, 16'h2040, 8'h00, 1'b0, 1'b1, 1'b0, 8'h60, 3);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/oc8051_xram_arbiter.md
Name: oc8051_xram_arbiter

Overview:
- Arbitrates XRAM requests from up to NUM_MST bus masters (CPU, DMA, crypto engines) onto one XRAM port.
- Drives the page table's access-check inputs (address, wr, stb, accesser id) and consumes its wr_en/rd_en verdicts.
- Forwards permitted accesses to XRAM and returns an error completion for denied ones.
- Routes page-table and illegal-access register addresses (0xFF80–0xFFC3) to the page table's register strobes instead of XRAM.

Parameters:
- NUM_MST, 4: number of masters, 1..8; the master index becomes the 3-bit accesser id.
- TIMEOUT, 255: maximum cycles to wait for mem_ack or a register ack, 1..255 (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_stb  in  NUM_MST  per-master request strobe; held until m_ack or m_err
- m_wr  in  NUM_MST  per-master write (1) / read (0)
- m_addr  in  16*NUM_MST  per-master address; master i uses [16i+15:16i]
- m_wdata  in  8*NUM_MST  per-master write data
- m_ack  out  NUM_MST  one-cycle completion pulse
- m_err  out  NUM_MST  one-cycle denied/timeout pulse
- m_rdata  out  8  read data shared by all masters; valid while m_ack is high
- chk_addr  out  16  page-table check address (xram_addr)
- chk_wr  out  1  page-table check write flag (xram_wr)
- chk_stb  out  1  page-table check strobe (xram_stb)
- chk_src  out  3  accesser id
- chk_wr_en  in  1  page-table write permission
- chk_rd_en  in  1  page-table read permission
- pt_stb  out  1  page-table register strobe
- ia_stb  out  1  illegal-access register strobe
- pt_ack  in  1  page-table register ack
- ia_ack  in  1  illegal-access register ack
- pt_rdata  in  8  page-table register read data
- ia_rdata  in  8  illegal-access register read data
- mem_stb  out  1  XRAM strobe
- mem_wr  out  1  XRAM write
- mem_addr  out  16  XRAM address
- mem_wdata  out  8  XRAM write data
- mem_rdata  in  8  XRAM read data
- mem_ack  in  1  XRAM ack

Behaviour:
- Reset: state IDLE; rr_ptr=0; all registered outputs 0; m_ack, m_err, chk_stb, pt_stb, ia_stb, mem_stb all 0.
- Reset mid-transaction abandons the access with no ack; masters must re-request.
- Arbitration in IDLE: round-robin over m_stb, starting the search at rr_ptr. After a grant to master g, rr_ptr=g+1 mod NUM_MST.
- On grant, the master's wr, addr and wdata are registered into cur_*, and cur_src=g.
- Decode on cur_addr:
  - REG region: 0xFF80–0xFFBF (page-table registers) or 0xFFC0–0xFFC3 (illegal-access registers).
  - MEM region: everything else.
- FSM states:
  - IDLE: no grant → stay. Grant in REG region → REG. Grant in MEM region → CHECK.
  - CHECK (exactly 1 cycle): chk_addr=cur_addr, chk_wr=cur_wr, chk_src=cur_src, chk_stb=1. Sample perm = cur_wr ? chk_wr_en : chk_rd_en. perm=1 → MEM. perm=0 → ERR.
    - chk_stb is high in CHECK only, so the page table logs each illegal access exactly once.
    - chk_addr/chk_wr/chk_src hold their last values in all other states.
  - MEM: mem_stb=1, mem_wr/addr/wdata from cur_*. On mem_ack: capture mem_rdata into m_rdata, go to RESP.
  - REG: pt_stb=1 for 0xFF80–0xFFBF, or ia_stb=1 for 0xFFC0–0xFFC3. On the matching ack: capture the matching rdata, go to RESP. No permission check here (the page table enforces privilege itself).
  - RESP: m_ack[cur_src]=1 for one cycle, then IDLE.
  - ERR: m_err[cur_src]=1 for one cycle, m_rdata=0, then IDLE.
- Latency (grant to ack):
  - MEM, zero-wait memory: 3 cycles (CHECK, MEM, RESP).
  - Denied access: m_err 2 cycles after grant.
  - REG access: 2 cycles minimum.
- An access is one transaction; a new grant is possible in the cycle after RESP/ERR.
- A master deasserting m_stb mid-transaction is a protocol violation; the transaction still completes.
- Simultaneous requests are serialised by round-robin; no master waits more than NUM_MST-1 transactions.
- Address 0xFFC4–0xFFFF is treated as MEM and is permission-checked.

Optional Feature:
- Macro: OC8051_XRAM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to MEM or REG and increments each cycle there.
  - On reaching TIMEOUT with no ack: go to ERR, drop mem_stb/pt_stb/ia_stb.
  - A late ack arriving in IDLE is ignored.
- Undefined: no counter; MEM and REG wait indefinitely.

Decomposition:
- Package oc8051_xram_pkg:
  - state enum {IDLE, CHECK, MEM, REG, RESP, ERR}.
  - Region constants: PT_WR_START 16'hFF80, PT_RD_END 16'hFFBF, IA_START 16'hFFC0, IA_END 16'hFFC3.
  - Accesser id width 3.
- Sub-module oc8051_rr_arbiter: request vector plus rr_ptr in; grant index and valid out; purely combinational.

Test Plan:
- Master 1 reads 0x1234 with chk_rd_en=1, mem_rdata=0xA5, zero-wait → chk_stb high exactly 1 cycle with chk_src=1; m_ack[1] 3 cycles after grant; m_rdata=0xA5.
- Master 0 writes 0x0800 with chk_wr_en=0 → no mem_stb; m_err[0] 2 cycles after grant; single chk_stb pulse with chk_wr=1.
- Masters 0, 2, 3 request simultaneously with rr_ptr=0 → grant order 0, 2, 3, then master 0 again if it re-requests.
- Master 2 writes 0xFF85=0x3C → pt_stb=1, mem_stb=0, chk_stb=0; m_ack[2] after pt_ack. Master 2 reads 0xFFC1 → ia_stb=1, ia_rdata returned.
- With OC8051_XRAM_ARB_TIMEOUT_EN and TIMEOUT=4, mem_ack held low → m_err at 4 cycles in MEM; a subsequent stray mem_ack is ignored.
- rst asserted while in MEM → next cycle IDLE, mem_stb=0, no m_ack/m_err.
